cheri_cst_seq: RTL
==================

Name: cheri_cst_seq

Overview:
- Capability-store sequencer for the CSTcso path; the write-side counterpart of the CLDcso load.
- On a start pulse it snapshots an authorising capability (address source) and a capability value.
- It performs tag, store-capability permission and bounds checks, then serialises the value into 12 consecutive 24-bit data-memory writes.
- Sits between the EX/MEM stage and the dcache write port.

Parameters:
- ADDR_W, 48, address and capability field width.
- DATA_W, 24, memory word width.
- PERM_SC_BIT, 2, bit index of the store-capability permission in i_auth_perms.

Ports:
- r_clk  in  1  clock
- r_rst  in  1  reset, asynchronous, active-low
- i_start  in  1  one-cycle request; ignored while o_busy=1
- i_addr  in  ADDR_W  effective store address (word 0)
- i_auth_base  in  ADDR_W  authorising capability base
- i_auth_len  in  ADDR_W  authorising capability length
- i_auth_perms  in  DATA_W  authorising capability permissions
- i_auth_tag  in  1  authorising capability tag
- i_cap_base, i_cap_len, i_cap_cur  in  ADDR_W  capability value fields
- i_cap_perms, i_cap_attr  in  DATA_W  capability value fields
- i_cap_tag  in  1  capability value tag
- o_busy  out  1  operation in progress
- o_done  out  1  one-cycle pulse: all 12 words written
- o_fault  out  1  one-cycle pulse: check failed, nothing written
- o_fault_code  out  2  0=tag, 1=perm, 2=bounds; valid with o_fault
- o_mem_req  out  1  write request
- o_mem_addr  out  ADDR_W  write address
- o_mem_wdata  out  DATA_W  write data
- i_mem_ack  in  1  write accepted on this rising edge when o_mem_req=1

Behaviour:
- Reset (r_rst=0, async): state IDLE; all outputs 0; word index 0; snapshot registers cleared.
- States:
  - IDLE: on i_start=1, snapshot all i_* inputs and go to CHECK.
  - CHECK: one cycle, evaluated on the snapshot, priority tag > perm > bounds.
    - auth_tag=0 -> FAULT with code 0.
    - perms[PERM_SC_BIT]=0 -> FAULT with code 1.
    - Bounds compared in ADDR_W+1 bits (no wrap): fault with code 2 unless addr >= base and addr+12 <= base+len.
    - Otherwise go to WRITE with idx=0.
  - WRITE: o_mem_req=1, o_mem_addr=addr+idx, o_mem_wdata=word(idx).
    - Addr and data are held stable until i_mem_ack=1 is sampled.
    - On ack: if idx=11 go to DONE, else idx+1 and o_mem_req stays high.
  - DONE: o_done=1 for one cycle, then IDLE.
  - FAULT: o_fault=1 and o_fault_code driven for one cycle, then IDLE. o_mem_req is never asserted.
- Word layout (idx:data):
  - 0 base[23:0]; 1 base[47:24]
  - 2 len lo; 3 len hi
  - 4 cur lo; 5 cur hi
  - 6 perms; 7 0
  - 8 attr; 9 0
  - 10 {23'b0,tag}; 11 0
- o_busy=1 in CHECK, WRITE, DONE and FAULT.
- Latency: start edge at cycle 0, CHECK at cycle 1, writes at cycles 2..13 with ack tied high, o_done at cycle 14.
  - Each ack stall cycle adds 1.
  - Fault path: o_fault at cycle 2.
- Boundary cases:
  - i_start while busy: ignored, no snapshot.
  - Input changes after the start cycle: no effect.
  - i_mem_ack while o_mem_req=0: ignored.
  - len=0: always a bounds fault.
  - addr+idx is computed in ADDR_W bits; the bounds check guarantees no wrap.
- Reset mid-operation: outputs drop to 0 immediately; the write in flight is abandoned; earlier words remain in memory; no done or fault is issued.
- o_done and o_fault are never high together.

Decomposition:
- Shared package cap_pkg, also used by the CLD path:
  - CAP_WORDS=12.
  - Word-offset constants (CAP_W_BASE_LO .. CAP_W_TAG_HI).
  - Fault codes CAP_FLT_TAG/PERM/BOUNDS.
  - Default PERM_SC_BIT and PERM_LC_BIT.
- One sub-module, cap_bounds_check: combinational (addr, base, len, nwords) -> in_bounds, using the extra-bit compare. Reusable by the CLD path.

Test Plan:
- Nominal store, ack tied high:
  - Stimulus: auth base=0, len=1000, tag=1, perms SC set; addr=500; cap base={7,42}, len={9,88}, cur={3,123}, perms=0xEE, attr=0xAA, tag=1.
  - Required: addresses 500..511 receive 42,7,88,9,123,3,0xEE,0,0xAA,0,1,0 in order, one per cycle at cycles 2..13; o_done at cycle 14.
- Permission and tag faults:
  - SC bit clear -> o_fault with code 1 at cycle 2, o_mem_req never high.
  - auth_tag=0 with SC clear -> code 0 (priority check).
- Bounds edge:
  - addr=988 -> passes, last write to address 999.
  - addr=989 -> code 2, no writes.
  - len=0, addr=0 -> code 2.
- Ack stall: ack withheld 3 cycles on idx 4 -> address 504 and data 123 held stable throughout; o_done at cycle 17; no duplicate or skipped word.
- Start while busy and input churn:
  - Second i_start at cycle 5 with different addr -> ignored.
  - Cap inputs changed after cycle 0 -> written data still matches the snapshot.
- Reset mid-write: drop r_rst during idx 6 -> all outputs 0 asynchronously; after release a new start completes the full nominal sequence.

Source files
------------

// File: rtl/cap_pkg.sv
// Shared capability-transfer constants for the CSTcso and CLDcso paths.
// Word offsets describe the 12-word in-memory capability layout.
package cap_pkg;

  localparam int CAP_WORDS = 12;

  localparam logic [3:0] CAP_W_BASE_LO  = 4'd0;
  localparam logic [3:0] CAP_W_BASE_HI  = 4'd1;
  localparam logic [3:0] CAP_W_LEN_LO   = 4'd2;
  localparam logic [3:0] CAP_W_LEN_HI   = 4'd3;
  localparam logic [3:0] CAP_W_CUR_LO   = 4'd4;
  localparam logic [3:0] CAP_W_CUR_HI   = 4'd5;
  localparam logic [3:0] CAP_W_PERMS    = 4'd6;
  localparam logic [3:0] CAP_W_PERMS_HI = 4'd7;
  localparam logic [3:0] CAP_W_ATTR     = 4'd8;
  localparam logic [3:0] CAP_W_ATTR_HI  = 4'd9;
  localparam logic [3:0] CAP_W_TAG      = 4'd10;
  localparam logic [3:0] CAP_W_TAG_HI   = 4'd11;

  localparam logic [1:0] CAP_FLT_TAG    = 2'd0;
  localparam logic [1:0] CAP_FLT_PERM   = 2'd1;
  localparam logic [1:0] CAP_FLT_BOUNDS = 2'd2;

  localparam int CAP_PERM_SC_BIT = 2;
  localparam int CAP_PERM_LC_BIT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WRITE,
    ST_DONE,
    ST_FAULT
  } cst_state_e;

endpackage

// File: rtl/cap_bounds_check.sv
// Combinational access-window check: [addr, addr+nwords) inside [base, base+len).
// One extra bit on both sides so neither sum can wrap.
module cap_bounds_check #(
  parameter int ADDR_W = 48
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] nwords,
  output logic              in_bounds
);

  logic [ADDR_W:0] acc_end;
  logic [ADDR_W:0] cap_end;
  logic            lo_ok;

  assign acc_end   = {1'b0, addr} + {1'b0, nwords};
  assign cap_end   = {1'b0, base} + {1'b0, len};
  assign lo_ok     = {1'b0, addr} >= {1'b0, base};
  assign in_bounds = lo_ok && (acc_end <= cap_end);

endmodule

// File: rtl/cheri_cst_seq.sv
// CSTcso store sequencer: snapshot, tag/perm/bounds check, then
// 12 serial data-memory writes of the capability value.
module cheri_cst_seq
  import cap_pkg::*;
#(
  parameter int ADDR_W      = 48,
  parameter int DATA_W      = 24,
  parameter int PERM_SC_BIT = CAP_PERM_SC_BIT
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] i_auth_base,
  input  logic [ADDR_W-1:0] i_auth_len,
  input  logic [DATA_W-1:0] i_auth_perms,
  input  logic              i_auth_tag,
  input  logic [ADDR_W-1:0] i_cap_base,
  input  logic [ADDR_W-1:0] i_cap_len,
  input  logic [ADDR_W-1:0] i_cap_cur,
  input  logic [DATA_W-1:0] i_cap_perms,
  input  logic [DATA_W-1:0] i_cap_attr,
  input  logic              i_cap_tag,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_fault,
  output logic [1:0]        o_fault_code,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack
);

  localparam logic [ADDR_W-1:0] NWORDS   = ADDR_W'(CAP_WORDS);
  localparam logic [3:0]        LAST_IDX = 4'(CAP_WORDS - 1);

  cst_state_e state, nxt;
  logic [3:0] idx, idx_nxt;
  logic       load;

  logic [ADDR_W-1:0] s_addr;
  logic [ADDR_W-1:0] s_auth_base;
  logic [ADDR_W-1:0] s_auth_len;
  logic [DATA_W-1:0] s_auth_perms;
  logic              s_auth_tag;
  logic [ADDR_W-1:0] s_cap_base;
  logic [ADDR_W-1:0] s_cap_len;
  logic [ADDR_W-1:0] s_cap_cur;
  logic [DATA_W-1:0] s_cap_perms;
  logic [DATA_W-1:0] s_cap_attr;
  logic              s_cap_tag;

  logic              in_bounds;
  logic              perm_ok;
  logic              chk_ok;
  logic [1:0]        chk_code;
  logic [DATA_W-1:0] word;
  logic              unused_perms;

  assign unused_perms = ^s_auth_perms;

  cap_bounds_check #(
    .ADDR_W(ADDR_W)
  ) u_bounds (
    .addr     (s_addr),
    .base     (s_auth_base),
    .len      (s_auth_len),
    .nwords   (NWORDS),
    .in_bounds(in_bounds)
  );

  assign perm_ok = s_auth_perms[PERM_SC_BIT];
  assign chk_ok  = s_auth_tag && perm_ok && in_bounds;

  // Tag outranks permission, which outranks bounds.
  always_comb begin
    chk_code = CAP_FLT_BOUNDS;
    if (!s_auth_tag) begin
      chk_code = CAP_FLT_TAG;
    end else if (!perm_ok) begin
      chk_code = CAP_FLT_PERM;
    end
  end

  always_comb begin
    word = '0;
    unique case (idx)
      CAP_W_BASE_LO:  word = s_cap_base[DATA_W-1:0];
      CAP_W_BASE_HI:  word = s_cap_base[2*DATA_W-1:DATA_W];
      CAP_W_LEN_LO:   word = s_cap_len[DATA_W-1:0];
      CAP_W_LEN_HI:   word = s_cap_len[2*DATA_W-1:DATA_W];
      CAP_W_CUR_LO:   word = s_cap_cur[DATA_W-1:0];
      CAP_W_CUR_HI:   word = s_cap_cur[2*DATA_W-1:DATA_W];
      CAP_W_PERMS:    word = s_cap_perms;
      CAP_W_PERMS_HI: word = '0;
      CAP_W_ATTR:     word = s_cap_attr;
      CAP_W_ATTR_HI:  word = '0;
      CAP_W_TAG:      word = {{(DATA_W-1){1'b0}}, s_cap_tag};
      CAP_W_TAG_HI:   word = '0;
      default:        word = '0;
    endcase
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      s_addr       <= '0;
      s_auth_base  <= '0;
      s_auth_len   <= '0;
      s_auth_perms <= '0;
      s_auth_tag   <= 1'b0;
      s_cap_base   <= '0;
      s_cap_len    <= '0;
      s_cap_cur    <= '0;
      s_cap_perms  <= '0;
      s_cap_attr   <= '0;
      s_cap_tag    <= 1'b0;
    end else begin
      state <= nxt;
      idx   <= idx_nxt;
      if (load) begin
        s_addr       <= i_addr;
        s_auth_base  <= i_auth_base;
        s_auth_len   <= i_auth_len;
        s_auth_perms <= i_auth_perms;
        s_auth_tag   <= i_auth_tag;
        s_cap_base   <= i_cap_base;
        s_cap_len    <= i_cap_len;
        s_cap_cur    <= i_cap_cur;
        s_cap_perms  <= i_cap_perms;
        s_cap_attr   <= i_cap_attr;
        s_cap_tag    <= i_cap_tag;
      end
    end
  end

  // Outputs decode from state so an async reset clears them at once.
  always_comb begin
    nxt          = state;
    idx_nxt      = idx;
    load         = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_fault      = 1'b0;
    o_fault_code = 2'b0;
    o_mem_req    = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    unique case (state)
      ST_IDLE: begin
        if (i_start) begin
          load = 1'b1;
          nxt  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        o_busy  = 1'b1;
        idx_nxt = '0;
        nxt     = chk_ok ? ST_WRITE : ST_FAULT;
      end
      ST_WRITE: begin
        o_busy      = 1'b1;
        o_mem_req   = 1'b1;
        o_mem_addr  = s_addr + ADDR_W'(idx);
        o_mem_wdata = word;
        if (i_mem_ack) begin
          if (idx == LAST_IDX) begin
            nxt = ST_DONE;
          end else begin
            idx_nxt = idx + 4'd1;
          end
        end
      end
      ST_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
        nxt    = ST_IDLE;
      end
      ST_FAULT: begin
        o_busy       = 1'b1;
        o_fault      = 1'b1;
        o_fault_code = chk_code;
        nxt          = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

endmodule
